// File: rtl/gpu_pkg.sv
// Shared types and width helpers for the GPU framebuffer write path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package gpu_pkg;

   // Two-state write-port owner: requesters (ARB) or the clear sequencer (CLEAR).
   typedef enum logic {
      ARB   = 1'b0,
      CLEAR = 1'b1
   } fbarb_state_t;

   // Width of a pixel coordinate for a given framebuffer dimension.
   function automatic int coord_bits(input int resolution);
      return $clog2(resolution);
   endfunction

   // Width of a palette index.
   function automatic int index_bits(input int palette_length);
      return $clog2(palette_length);
   endfunction

   // Width of a requester id; never narrower than one bit.
   function automatic int id_bits(input int num_req);
      return (num_req > 1) ? $clog2(num_req) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first valid requester after the last winner.
// Latency: grant/id are combinational from valid; pointer updates on the clock edge.
// Backpressure: pointer only moves when the caller reports a completed transfer (advance).
//
// Ports:
//   clk, reset  clock and synchronous active-low reset
//   valid       per-requester request
//   advance     a transfer to the current winner completes this cycle
//   grant       one-hot winner (all zero when nothing is valid)
//   id          binary index of the winner
module rr_arbiter
   import gpu_pkg::*;
#(
   parameter  int N       = 2,
   localparam int ID_BITS = id_bits(N)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N-1:0]       valid,
   input  logic               advance,
   output logic [N-1:0]       grant,
   output logic [ID_BITS-1:0] id
);

   logic [ID_BITS-1:0] last;
   logic [ID_BITS-1:0] cand;
   logic               found;

   // Search last+1, last+2, ... wrapping; the last winner is visited last.
   always_comb begin
      grant = '0;
      id    = '0;
      cand  = '0;
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
         cand = ID_BITS'((int'(last) + k) % N);
         if (!found && valid[cand]) begin
            found       = 1'b1;
            id          = cand;
            grant[cand] = 1'b1;
         end
      end
   end

   // Reset to N-1 so requester 0 has first priority.
   always_ff @(posedge clk) begin
      if (!reset) begin
         last <= ID_BITS'(N - 1);
      end else if (advance && found) begin
         last <= id;
      end
   end

endmodule

// File: rtl/fb_write_arbiter.sv
// Shares the framebuffer write port between NUM_REQ requesters plus a full-frame clear sequencer.
// Latency: accepted beat appears on fb_wr_* one cycle later; clear writes one pixel per cycle from N+1.
// Backpressure: combinational req_ready (one winner, none while clearing or on clear_start); fb port never stalls.
//
// Ports:
//   clk, reset                     clock and synchronous active-low reset
//   req_valid/req_ready            per-requester handshake
//   req_x/req_y/req_index          packed payloads, requester i at [i*W +: W]
//   clear_start/clear_index        start pulse and fill index for a full-frame clear
//   clear_busy                     clear in progress
//   fb_wr_x/y/index/en             registered framebuffer write
//   grant_id                       source of the current write (0 during clear)
module fb_write_arbiter
   import gpu_pkg::*;
#(
   parameter  int RESOLUTION_X   = 400,
   parameter  int RESOLUTION_Y   = 300,
   parameter  int PALETTE_LENGTH = 256,
   parameter  int NUM_REQ        = 2,
   localparam int X_BITS         = coord_bits(RESOLUTION_X),
   localparam int Y_BITS         = coord_bits(RESOLUTION_Y),
   localparam int INDEX_BITS     = index_bits(PALETTE_LENGTH),
   localparam int ID_BITS        = id_bits(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ*X_BITS-1:0]     req_x,
   input  logic [NUM_REQ*Y_BITS-1:0]     req_y,
   input  logic [NUM_REQ*INDEX_BITS-1:0] req_index,
   input  logic                          clear_start,
   input  logic [INDEX_BITS-1:0]         clear_index,
   output logic                          clear_busy,
   output logic [X_BITS-1:0]             fb_wr_x,
   output logic [Y_BITS-1:0]             fb_wr_y,
   output logic [INDEX_BITS-1:0]         fb_wr_index,
   output logic                          fb_wr_en,
   output logic [ID_BITS-1:0]            grant_id
);

   fbarb_state_t            state;
   fbarb_state_t            state_nxt;
   logic [X_BITS-1:0]       cx;
   logic [Y_BITS-1:0]       cy;
   logic [X_BITS-1:0]       cx_nxt;
   logic [Y_BITS-1:0]       cy_nxt;
   logic [INDEX_BITS-1:0]   fill;
   logic                    clear_last;
   logic                    clear_accept;
   logic                    xfer;
   logic [NUM_REQ-1:0]      arb_grant;
   logic [ID_BITS-1:0]      arb_id;
   logic [X_BITS-1:0]       sel_x;
   logic [Y_BITS-1:0]       sel_y;
   logic [INDEX_BITS-1:0]   sel_index;
   logic                    in_range;

   rr_arbiter #(
      .N(NUM_REQ)
   ) u_rr (
      .clk    (clk),
      .reset  (reset),
      .valid  (req_valid),
      .advance(xfer),
      .grant  (arb_grant),
      .id     (arb_id)
   );

   // cx/cy name the pixel currently on the fb_wr outputs during a clear.
   assign clear_last = (cx == X_BITS'(RESOLUTION_X - 1)) && (cy == Y_BITS'(RESOLUTION_Y - 1));

   always_comb begin
      cx_nxt = cx + X_BITS'(1);
      cy_nxt = cy;
      if (cx == X_BITS'(RESOLUTION_X - 1)) begin
         cx_nxt = '0;
         cy_nxt = cy + Y_BITS'(1);
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= ARB;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         ARB:     if (clear_start) state_nxt = CLEAR;
         CLEAR:   if (clear_last)  state_nxt = ARB;
         default: state_nxt = ARB;
      endcase
   end

   // Output decode. clear_start suppresses grants in the same cycle so the
   // clear always wins the port; a start while busy is simply not decoded.
   always_comb begin
      req_ready    = '0;
      clear_busy   = 1'b0;
      clear_accept = 1'b0;
      case (state)
         ARB: begin
            clear_accept = clear_start;
            if (!clear_start) req_ready = arb_grant;
         end
         CLEAR:   clear_busy = 1'b1;
         default: ;
      endcase
   end

   assign xfer = |(req_valid & req_ready);

   // Winner payload mux.
   assign sel_x     = req_x[int'(arb_id)*X_BITS +: X_BITS];
   assign sel_y     = req_y[int'(arb_id)*Y_BITS +: Y_BITS];
   assign sel_index = req_index[int'(arb_id)*INDEX_BITS +: INDEX_BITS];
   assign in_range  = (int'(sel_x) < RESOLUTION_X) && (int'(sel_y) < RESOLUTION_Y);

   // Clear counters and registered write port. Out-of-range beats are
   // consumed without a write and leave the held coordinates untouched.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cx          <= '0;
         cy          <= '0;
         fill        <= '0;
         fb_wr_x     <= '0;
         fb_wr_y     <= '0;
         fb_wr_index <= '0;
         fb_wr_en    <= 1'b0;
         grant_id    <= '0;
      end else begin
         fb_wr_en <= 1'b0;
         if (clear_accept) begin
            fill        <= clear_index;
            cx          <= '0;
            cy          <= '0;
            fb_wr_x     <= '0;
            fb_wr_y     <= '0;
            fb_wr_index <= clear_index;
            fb_wr_en    <= 1'b1;
            grant_id    <= '0;
         end else if (state == CLEAR && !clear_last) begin
            cx          <= cx_nxt;
            cy          <= cy_nxt;
            fb_wr_x     <= cx_nxt;
            fb_wr_y     <= cy_nxt;
            fb_wr_index <= fill;
            fb_wr_en    <= 1'b1;
         end else if (xfer && in_range) begin
            fb_wr_x     <= sel_x;
            fb_wr_y     <= sel_y;
            fb_wr_index <= sel_index;
            fb_wr_en    <= 1'b1;
            grant_id    <= arb_id;
         end
      end
   end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Self-checking bench for fb_write_arbiter: table-driven arbitration vectors plus clear sequences.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_fb_write_arbiter;

   localparam int RX   = 400;
   localparam int RY   = 10;
   localparam int NPIX = RX * RY;
   localparam int XB   = 9;
   localparam int YB   = 4;
   localparam int IB   = 8;

   logic            clk;
   logic            reset;
   logic [1:0]      req_valid;
   logic [1:0]      req_ready;
   logic [2*XB-1:0] req_x;
   logic [2*YB-1:0] req_y;
   logic [2*IB-1:0] req_index;
   logic            clear_start;
   logic [IB-1:0]   clear_index;
   logic            clear_busy;
   logic [XB-1:0]   fb_wr_x;
   logic [YB-1:0]   fb_wr_y;
   logic [IB-1:0]   fb_wr_index;
   logic            fb_wr_en;
   logic            grant_id;

   int total;
   int bad;

   fb_write_arbiter #(
      .RESOLUTION_X  (RX),
      .RESOLUTION_Y  (RY),
      .PALETTE_LENGTH(256),
      .NUM_REQ       (2)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_x      (req_x),
      .req_y      (req_y),
      .req_index  (req_index),
      .clear_start(clear_start),
      .clear_index(clear_index),
      .clear_busy (clear_busy),
      .fb_wr_x    (fb_wr_x),
      .fb_wr_y    (fb_wr_y),
      .fb_wr_index(fb_wr_index),
      .fb_wr_en   (fb_wr_en),
      .grant_id   (grant_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]    valid;
      logic [XB-1:0] x0;
      logic [YB-1:0] y0;
      logic [IB-1:0] i0;
      logic [XB-1:0] x1;
      logic [YB-1:0] y1;
      logic [IB-1:0] i1;
      logic [1:0]    exp_rdy;
      logic          exp_en;
      logic          chk_dat;
      logic [XB-1:0] exp_x;
      logic [YB-1:0] exp_y;
      logic [IB-1:0] exp_idx;
      logic          exp_gid;
   } vec_t;

   localparam int NV = 14;
   vec_t tv [NV];

   function automatic vec_t mk(input logic [1:0] v,
                               input int x0, input int y0, input int i0,
                               input int x1, input int y1, input int i1,
                               input logic [1:0] rdy, input logic en, input logic cd,
                               input int ex, input int ey, input int ei, input logic eg);
      vec_t r;
      r.valid   = v;
      r.x0      = XB'(x0);
      r.y0      = YB'(y0);
      r.i0      = IB'(i0);
      r.x1      = XB'(x1);
      r.y1      = YB'(y1);
      r.i1      = IB'(i1);
      r.exp_rdy = rdy;
      r.exp_en  = en;
      r.chk_dat = cd;
      r.exp_x   = XB'(ex);
      r.exp_y   = YB'(ey);
      r.exp_idx = IB'(ei);
      r.exp_gid = eg;
      return r;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Advance one cycle; return at the falling edge, away from the active edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Run one full-frame clear with fill index 'fill'. Optionally pulse
   // clear_start at pixel pulse_at, or assert reset at pixel reset_at.
   task automatic sweep(input logic [7:0] fill, input int pulse_at, input int reset_at,
                        input logic [1:0] exp_rdy_after, input string nm);
      int errs;
      errs = 0;
      clear_start = 1'b1;
      clear_index = fill;
      #1;
      check({nm, "_start_ready"}, 32'(req_ready), 32'd0);
      step();
      clear_start = 1'b0;
      clear_index = 8'h00;
      for (int k = 0; k < NPIX; k++) begin
         if (!(fb_wr_en === 1'b1 && fb_wr_x === XB'(k % RX) && fb_wr_y === YB'(k / RX) &&
               fb_wr_index === fill && clear_busy === 1'b1 && req_ready === 2'b00 &&
               grant_id === 1'b0)) begin
            if (errs == 0)
               $display("note: %s first bad pixel %0d: en=%b x=%0d y=%0d idx=%h busy=%b rdy=%b",
                        nm, k, fb_wr_en, fb_wr_x, fb_wr_y, fb_wr_index, clear_busy, req_ready);
            errs++;
         end
         if (k == reset_at) begin
            reset = 1'b0;
            step();
            reset = 1'b1;
            check({nm, "_pixels_before_reset"}, 32'(errs), 32'd0);
            check({nm, "_reset_en"}, 32'(fb_wr_en), 32'd0);
            check({nm, "_reset_busy"}, 32'(clear_busy), 32'd0);
            return;
         end
         if (k == pulse_at) begin
            clear_start = 1'b1;
            clear_index = ~fill;
            #1;
            if (req_ready !== 2'b00) errs++;
         end
         step();
         clear_start = 1'b0;
         clear_index = 8'h00;
      end
      check({nm, "_pixels"}, 32'(errs), 32'd0);
      check({nm, "_busy_after"}, 32'(clear_busy), 32'd0);
      check({nm, "_en_after"}, 32'(fb_wr_en), 32'd0);
      #1;
      check({nm, "_ready_after"}, 32'(req_ready), 32'(exp_rdy_after));
   endtask

   initial begin
      total       = 0;
      bad         = 0;
      reset       = 1'b0;
      req_valid   = '0;
      req_x       = '0;
      req_y       = '0;
      req_index   = '0;
      clear_start = 1'b0;
      clear_index = '0;

      // Pointer starts at 1: requester 0 has first priority after reset.
      tv[0]  = mk(2'b00,   0, 0, 'h00,   0, 0, 'h00, 2'b00, 0, 1,   0, 0, 'h00, 0);
      tv[1]  = mk(2'b01,   5, 7, 'h3C,   0, 0, 'h00, 2'b01, 1, 1,   5, 7, 'h3C, 0);
      tv[2]  = mk(2'b10,   0, 0, 'h00,   1, 2, 'h55, 2'b10, 1, 1,   1, 2, 'h55, 1);
      tv[3]  = mk(2'b11,  10, 2, 'hA1,  30, 6, 'hB2, 2'b01, 1, 1,  10, 2, 'hA1, 0);
      tv[4]  = mk(2'b11,  10, 2, 'hA1,  30, 6, 'hB2, 2'b10, 1, 1,  30, 6, 'hB2, 1);
      tv[5]  = mk(2'b11,  10, 2, 'hA1,  30, 6, 'hB2, 2'b01, 1, 1,  10, 2, 'hA1, 0);
      tv[6]  = mk(2'b11,  10, 2, 'hA1,  30, 6, 'hB2, 2'b10, 1, 1,  30, 6, 'hB2, 1);
      tv[7]  = mk(2'b11,  10, 2, 'hA1,  30, 6, 'hB2, 2'b01, 1, 1,  10, 2, 'hA1, 0);
      tv[8]  = mk(2'b11,  10, 2, 'hA1,  30, 6, 'hB2, 2'b10, 1, 1,  30, 6, 'hB2, 1);
      tv[9]  = mk(2'b01, 400, 0, 'h12,   0, 0, 'h00, 2'b01, 0, 0,   0, 0, 'h00, 0);
      tv[10] = mk(2'b10,   0, 0, 'h00,   3, 10,'h34, 2'b10, 0, 0,   0, 0, 'h00, 0);
      tv[11] = mk(2'b01, 399, 9, 'hFF,   0, 0, 'h00, 2'b01, 1, 1, 399, 9, 'hFF, 0);
      tv[12] = mk(2'b11,   8, 8, 'h66,  17, 3, 'h5A, 2'b10, 1, 1,  17, 3, 'h5A, 1);
      tv[13] = mk(2'b00,   0, 0, 'h00,   0, 0, 'h00, 2'b00, 0, 1,  17, 3, 'h5A, 1);

      // Reset held for three cycles.
      @(negedge clk);
      repeat (3) step();
      check("rst_en",    32'(fb_wr_en),    32'd0);
      check("rst_busy",  32'(clear_busy),  32'd0);
      check("rst_ready", 32'(req_ready),   32'd0);
      check("rst_x",     32'(fb_wr_x),     32'd0);
      check("rst_y",     32'(fb_wr_y),     32'd0);
      check("rst_idx",   32'(fb_wr_index), 32'd0);
      check("rst_gid",   32'(grant_id),    32'd0);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("idle%0d_en", i), 32'(fb_wr_en), 32'd0);
      end

      // Arbitration vectors.
      for (int i = 0; i < NV; i++) begin
         req_valid = tv[i].valid;
         req_x     = {tv[i].x1, tv[i].x0};
         req_y     = {tv[i].y1, tv[i].y0};
         req_index = {tv[i].i1, tv[i].i0};
         #1;
         check($sformatf("v%0d_ready", i), 32'(req_ready), 32'(tv[i].exp_rdy));
         step();
         check($sformatf("v%0d_en", i), 32'(fb_wr_en), 32'(tv[i].exp_en));
         if (tv[i].chk_dat) begin
            check($sformatf("v%0d_x", i),   32'(fb_wr_x),     32'(tv[i].exp_x));
            check($sformatf("v%0d_y", i),   32'(fb_wr_y),     32'(tv[i].exp_y));
            check($sformatf("v%0d_idx", i), 32'(fb_wr_index), 32'(tv[i].exp_idx));
            check($sformatf("v%0d_gid", i), 32'(grant_id),    32'(tv[i].exp_gid));
         end
      end

      // Full clear with requester 1 waiting; it wins the cycle busy drops.
      req_valid = 2'b10;
      req_x     = {9'd7, 9'd0};
      req_y     = {4'd4, 4'd0};
      req_index = {8'h99, 8'h00};
      sweep(8'h11, -1, -1, 2'b10, "clr_a");
      step();
      check("clr_a_req_en",  32'(fb_wr_en),    32'd1);
      check("clr_a_req_x",   32'(fb_wr_x),     32'd7);
      check("clr_a_req_y",   32'(fb_wr_y),     32'd4);
      check("clr_a_req_idx", 32'(fb_wr_index), 32'h99);
      check("clr_a_req_gid", 32'(grant_id),    32'd1);
      req_valid = 2'b00;
      step();
      check("clr_a_idle_en", 32'(fb_wr_en), 32'd0);

      // Clear restart attempt mid-sweep must be ignored.
      sweep(8'h22, 500, -1, 2'b00, "clr_b");

      // Reset in the middle of a clear, then normal grant from requester 0.
      sweep(8'h33, -1, 1000, 2'b00, "clr_c");
      req_valid = 2'b11;
      req_x     = {9'd200, 9'd12};
      req_y     = {4'd1, 4'd3};
      req_index = {8'h88, 8'h44};
      #1;
      check("post_rst_ready", 32'(req_ready), 32'b01);
      step();
      check("post_rst_en",  32'(fb_wr_en),    32'd1);
      check("post_rst_x",   32'(fb_wr_x),     32'd12);
      check("post_rst_y",   32'(fb_wr_y),     32'd3);
      check("post_rst_idx", 32'(fb_wr_index), 32'h44);
      check("post_rst_gid", 32'(grant_id),    32'd0);
      req_valid = 2'b00;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
